// File: rtl/sel_mux_blank.sv
// Registered N:1 channel mux. A select change blanks (holds z) for BLANK cycles
// before switching, so the output never shows a partial word.
//   state    | meaning
//   ST_IDLE  | z tracks i[cur_sel]; requests are evaluated
//   ST_BLANK | z frozen; waiting out the hold before switching to pending
module sel_mux_blank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int BLANK    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          z,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      busy,
  output logic                      err
);

  localparam int CNT_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  typedef enum logic {ST_IDLE, ST_BLANK} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] cur_data, pend_data, sel_data;
  logic             sel_valid;

  always_comb begin
    cur_data  = '0;
    pend_data = '0;
    sel_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_sel_q == SEL_W'(k)) cur_data  = i[k*WIDTH +: WIDTH];
      if (pending_q == SEL_W'(k)) pend_data = i[k*WIDTH +: WIDTH];
      if (sel == SEL_W'(k))       sel_data  = i[k*WIDTH +: WIDTH];
    end
  end

  assign sel_valid = (32'(sel) < CHANNELS);

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    if (sel_load && !sel_valid) err_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        z_d = cur_data;
        if (sel_load && sel_valid && (sel != cur_sel_q)) begin
          if (BLANK > 0) begin
            pending_d = sel;
            cnt_d     = CNT_W'(BLANK - 1);
            busy_d    = 1'b1;
            state_d   = ST_BLANK;
            z_d       = z_q;
          end else begin
            cur_sel_d = sel;
            z_d       = sel_data;
          end
        end
      end
      ST_BLANK: begin
        // Restart and cancel pre-empt completion; ignored or rejected requests do not.
        if (sel_load && sel_valid && (sel == cur_sel_q)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sel_load && sel_valid && (sel != pending_q)) begin
          pending_d = sel;
          cnt_d     = CNT_W'(BLANK - 1);
        end else if (cnt_q == '0) begin
          cur_sel_d = pending_q;
          z_d       = pend_data;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_sel_q <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      z_q       <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign z       = z_q;
  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sel_mux_blank.sv
// Bench for sel_mux_blank: default, 3-channel and zero-blank builds, checked
// against an edge-counting reference model with directed and random stimulus.
module tb_sel_mux_blank;

  typedef struct {
    int       cur;
    int       tgt;   // -1 when no switch is outstanding
    int       left;  // edges remaining until the switch lands
    bit [3:0] z;
    bit       err;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ia;  logic [1:0] sa;  logic la;
  logic [11:0] ic;  logic [1:0] sc;  logic lc;
  logic [15:0] iz;  logic [1:0] sz;  logic lz;
  logic [3:0] za, zc, zz;
  logic [1:0] ca, cc, cz;
  logic ba, bc, bz, ea, ec, ez;

  sel_mux_blank #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .BLANK(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .i(ia), .sel(sa), .sel_load(la),
    .z(za), .cur_sel(ca), .busy(ba), .err(ea));
  sel_mux_blank #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .BLANK(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .i(ic), .sel(sc), .sel_load(lc),
    .z(zc), .cur_sel(cc), .busy(bc), .err(ec));
  sel_mux_blank #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .BLANK(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .i(iz), .sel(sz), .sel_load(lz),
    .z(zz), .cur_sel(cz), .busy(bz), .err(ez));

  int n_vec = 0;
  int n_err = 0;
  model_t ma, mc, mz;

  function automatic model_t m_reset();
    model_t m;
    m.cur = 0; m.tgt = -1; m.left = 0; m.z = 4'h0; m.err = 1'b0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int nch, int nb, logic [15:0] d, int s, bit ld);
    model_t n;
    bit ok;
    n = m;
    n.err = ld && (s >= nch);
    ok = ld && (s < nch);
    if (m.tgt < 0) begin
      n.z = d[m.cur*4 +: 4];
      if (ok && s != m.cur) begin
        if (nb == 0) begin
          n.cur = s;
          n.z = d[s*4 +: 4];
        end else begin
          n.tgt = s;
          n.left = nb;
          n.z = m.z;
        end
      end
    end else if (ok && s == m.cur) begin
      n.tgt = -1;
    end else if (ok && s != m.tgt) begin
      n.tgt = s;
      n.left = nb;
    end else begin
      n.left = m.left - 1;
      if (n.left == 0) begin
        n.cur = m.tgt;
        n.z = d[m.tgt*4 +: 4];
        n.tgt = -1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input logic [3:0] z, input logic [1:0] c,
                          input logic b, input logic e, input model_t m);
    chk({nm, ".z"}, z, m.z);
    chk({nm, ".cur_sel"}, {2'b00, c}, 4'(m.cur));
    chk({nm, ".busy"}, {3'b000, b}, {3'b000, m.tgt >= 0});
    chk({nm, ".err"}, {3'b000, e}, {3'b000, m.err});
  endtask

  task automatic check_all();
    chk_inst("a", za, ca, ba, ea, ma);
    chk_inst("c", zc, cc, bc, ec, mc);
    chk_inst("z", zz, cz, bz, ez, mz);
  endtask

  // One clock edge: advance the models with the inputs the DUTs sample, then check.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      ma = step(ma, 4, 3, ia, int'(sa), la);
      mc = step(mc, 3, 3, {4'h0, ic}, int'(sc), lc);
      mz = step(mz, 4, 0, iz, int'(sz), lz);
    end
    #1;
    check_all();
  endtask

  task automatic reset_models();
    ma = m_reset(); mc = m_reset(); mz = m_reset();
  endtask

  initial begin
    ia = '0; sa = '0; la = 1'b0;
    ic = '0; sc = '0; lc = 1'b0;
    iz = '0; sz = '0; lz = 1'b0;
    reset_models();
    #2;
    check_all();
    cyc();
    rst_n = 1'b1;

    // Idle tracking
    ia = 16'hD5A3; ic = 12'h5A3; iz = 16'hD5A3;
    cyc();
    chk("t1.z_first", za, 4'h3);
    ia[3:0] = 4'h7;
    cyc();
    chk("t1.z_track", za, 4'h7);

    // Normal switch to channel 2
    sa = 2'd2; la = 1'b1;
    cyc();
    chk("t2.busy_E0", {3'b0, ba}, 4'h1);
    la = 1'b0;
    cyc(); cyc();
    chk("t2.z_held", za, 4'h7);
    cyc();
    chk("t2.cur_E3", {2'b0, ca}, 4'h2);
    chk("t2.z_E3", za, 4'h5);
    ia[11:8] = 4'hA;
    cyc();
    chk("t2.z_track", za, 4'hA);

    // Out-of-range request on the 3-channel build
    sc = 2'd3; lc = 1'b1;
    cyc();
    chk("t3.err", {3'b0, ec}, 4'h1);
    lc = 1'b0;
    cyc();
    chk("t3.err_drop", {3'b0, ec}, 4'h0);

    // Restart: ch1 then ch3 one edge later
    sa = 2'd1; la = 1'b1;
    cyc();
    sa = 2'd3;
    cyc();
    la = 1'b0;
    cyc(); cyc();
    chk("t4.busy_restart", {3'b0, ba}, 4'h1);
    cyc();
    chk("t4.cur_restart", {2'b0, ca}, 4'h3);
    // Cancel: ch1 then the current ch3 mid-blank
    sa = 2'd1; la = 1'b1;
    cyc();
    la = 1'b0;
    cyc();
    sa = 2'd3; la = 1'b1;
    cyc();
    la = 1'b0;
    chk("t4.busy_cancel", {3'b0, ba}, 4'h0);
    for (int k = 0; k < 4; k++) cyc();
    chk("t4.cur_cancel", {2'b0, ca}, 4'h3);

    // Zero-blank switch
    sz = 2'd1; lz = 1'b1;
    cyc();
    lz = 1'b0;
    chk("t6.cur", {2'b0, cz}, 4'h1);
    chk("t6.z", zz, 4'hA);
    chk("t6.busy", {3'b0, bz}, 4'h0);

    // Asynchronous reset while blanking
    sa = 2'd0; la = 1'b1;
    cyc();
    la = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_models();
    check_all();
    chk("t5.z", za, 4'h0);
    cyc();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk("t5.no_switch", {2'b0, ca}, 4'h0);

    // Random phase
    for (int n = 0; n < 400; n++) begin
      ia = 16'($urandom); ic = 12'($urandom); iz = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        sa = 2'($urandom); sc = 2'($urandom); sz = 2'($urandom);
      end
      la = ($urandom_range(0, 9) < 3);
      lc = ($urandom_range(0, 9) < 3);
      lz = ($urandom_range(0, 9) < 3);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
